// File: rtl/pc_stack.sv
// Fetch-stage program counter with signed relative branch and a hardware
// return-address stack for call/return, with sticky overflow/underflow flags.
module pc_stack #(
  parameter  int WIDTH     = 20,
  parameter  int STEP      = 1,
  parameter  int DEPTH     = 4,
  parameter  int RESET_VEC = 0,
  localparam int SPW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             write_en,
  input  logic [WIDTH-1:0] write_data,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_off,
  input  logic             call,
  input  logic             ret,
  input  logic             clr_err,
  output logic [WIDTH-1:0] ctr,
  output logic [SPW-1:0]   sp,
  output logic             stk_empty,
  output logic             stk_full,
  output logic             ovf,
  output logic             udf
);

  localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RESET_VEC);
  localparam logic [SPW-1:0]   SP_FULL = SPW'(DEPTH);

  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] ctr_nx;
  logic [SPW-1:0]   sp_nx;
  logic             push, ovf_set, udf_set;

  // Single action per cycle: ret > call > write_en > branch_en > inc.
  always_comb begin
    ctr_nx  = ctr;
    sp_nx   = sp;
    push    = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (ret) begin
      if (sp != '0) begin
        ctr_nx = stack[AW'(sp - SPW'(1))];
        sp_nx  = sp - SPW'(1);
      end else begin
        udf_set = 1'b1;
      end
    end else if (call) begin
      if (sp != SP_FULL) begin
        push   = 1'b1;
        ctr_nx = write_data;
        sp_nx  = sp + SPW'(1);
      end else begin
        ovf_set = 1'b1;
      end
    end else if (write_en) begin
      ctr_nx = write_data;
    end else if (branch_en) begin
      ctr_nx = ctr + branch_off;
    end else if (inc) begin
      ctr_nx = ctr + STEP_W;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr       <= RST_W;
      sp        <= '0;
      stk_empty <= 1'b1;
      stk_full  <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      ctr       <= ctr_nx;
      sp        <= sp_nx;
      stk_empty <= (sp_nx == '0);
      stk_full  <= (sp_nx == SP_FULL);
      // A fresh error in the clearing cycle takes precedence over the clear.
      ovf       <= ovf_set | (ovf & ~clr_err);
      udf       <= udf_set | (udf & ~clr_err);
    end
  end

  // Stack storage needs no reset: entries above sp are never read.
  always_ff @(posedge clk) begin
    if (push) stack[AW'(sp)] <= ctr + STEP_W;
  end

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed vector table, async reset
// sequences and randomized traffic against a queue-based reference model.
module tb_pc_stack;

  localparam int W = 20;
  localparam int D = 4;

  logic         clk, rst;
  logic         inc, write_en, branch_en, call, ret, clr_err;
  logic [W-1:0] write_data, branch_off;
  logic [W-1:0] ctr;
  logic [2:0]   sp;
  logic         stk_empty, stk_full, ovf, udf;

  pc_stack #(.WIDTH(W), .STEP(1), .DEPTH(D), .RESET_VEC(0)) dut (
    .clk(clk), .rst(rst), .inc(inc), .write_en(write_en),
    .write_data(write_data), .branch_en(branch_en), .branch_off(branch_off),
    .call(call), .ret(ret), .clr_err(clr_err), .ctr(ctr), .sp(sp),
    .stk_empty(stk_empty), .stk_full(stk_full), .ovf(ovf), .udf(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain arithmetic plus a queue of return addresses.
  logic [W-1:0] m_ctr;
  logic [W-1:0] m_q[$];
  logic         m_ovf, m_udf;

  task automatic model_reset();
    m_ctr = '0;
    m_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_step();
    bit os, us;
    os = 0; us = 0;
    if (ret) begin
      if (m_q.size() > 0) m_ctr = m_q.pop_back();
      else us = 1;
    end else if (call) begin
      if (m_q.size() < D) begin
        m_q.push_back(m_ctr + 1);
        m_ctr = write_data;
      end else os = 1;
    end else if (write_en)  m_ctr = write_data;
    else if (branch_en)     m_ctr = m_ctr + branch_off;
    else if (inc)           m_ctr = m_ctr + 1;
    m_ovf = os | (m_ovf & !clr_err);
    m_udf = us | (m_udf & !clr_err);
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] e_ctr, input int e_sp,
                           input logic e_ovf, input logic e_udf);
    check({tag, ".ctr"},   32'(ctr), 32'(e_ctr));
    check({tag, ".sp"},    32'(sp), 32'(e_sp));
    check({tag, ".empty"}, 32'(stk_empty), 32'(e_sp == 0));
    check({tag, ".full"},  32'(stk_full), 32'(e_sp == D));
    check({tag, ".ovf"},   32'(ovf), 32'(e_ovf));
    check({tag, ".udf"},   32'(udf), 32'(e_udf));
  endtask

  task automatic idle_inputs();
    inc = 0; write_en = 0; branch_en = 0; call = 0; ret = 0; clr_err = 0;
    write_data = '0; branch_off = '0;
  endtask

  // Assert reset between edges; outputs must clear with no clock edge, and
  // requests presented while reset is held must be ignored.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_all({tag, ".async"}, '0, 0, 1'b0, 1'b0);
    inc = 1; call = 1; write_data = 20'h12345;
    @(posedge clk);
    #1 check_all({tag, ".held"}, '0, 0, 1'b0, 1'b0);
    idle_inputs();
    rst = 1'b1;
    model_reset();
  endtask

  localparam int OR = 1, OC = 2, OW = 4, OB = 8, OI = 16, OX = 32;

  typedef struct {
    int           ops;
    logic [W-1:0] d;
    logic [W-1:0] e_ctr;
    int           e_sp;
    logic         e_ovf;
    logic         e_udf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int ops, logic [W-1:0] d, logic [W-1:0] e_ctr, int e_sp,
                              logic e_ovf, logic e_udf);
    vec_t v;
    v.ops = ops; v.d = d; v.e_ctr = e_ctr; v.e_sp = e_sp; v.e_ovf = e_ovf; v.e_udf = e_udf;
    return v;
  endfunction

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b0;
    #7 rst = 1'b1;
    check_all("reset", '0, 0, 1'b0, 1'b0);

    // Free-running increment from reset.
    inc = 1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1 check($sformatf("inc%0d", i), 32'(ctr), 32'(i));
    end
    inc = 0;
    async_reset("rst1");

    // Directed sequence from reset: wrap, branch, call/ret, full/empty, priority.
    tbl.push_back(mk(OW, 20'hFFFFE, 20'hFFFFE, 0, 0, 0));
    tbl.push_back(mk(OI, 20'h0,     20'hFFFFF, 0, 0, 0));
    tbl.push_back(mk(OI, 20'h0,     20'h00000, 0, 0, 0));
    tbl.push_back(mk(OI, 20'h0,     20'h00001, 0, 0, 0));
    tbl.push_back(mk(OW, 20'h00100, 20'h00100, 0, 0, 0));
    tbl.push_back(mk(OB, 20'hFFFF0, 20'h000F0, 0, 0, 0));
    tbl.push_back(mk(OB, 20'h00020, 20'h00110, 0, 0, 0));
    tbl.push_back(mk(OW, 20'h00010, 20'h00010, 0, 0, 0));
    tbl.push_back(mk(OC, 20'h3BEEF, 20'h3BEEF, 1, 0, 0));
    tbl.push_back(mk(OC, 20'h01000, 20'h01000, 2, 0, 0));
    tbl.push_back(mk(OR, 20'h0,     20'h3BEF0, 1, 0, 0));
    tbl.push_back(mk(OR, 20'h0,     20'h00011, 0, 0, 0));
    tbl.push_back(mk(OC, 20'h00100, 20'h00100, 1, 0, 0));
    tbl.push_back(mk(OC, 20'h00200, 20'h00200, 2, 0, 0));
    tbl.push_back(mk(OC, 20'h00300, 20'h00300, 3, 0, 0));
    tbl.push_back(mk(OC, 20'h00400, 20'h00400, 4, 0, 0));
    tbl.push_back(mk(OC, 20'h00500, 20'h00400, 4, 1, 0));
    tbl.push_back(mk(OR, 20'h0,     20'h00301, 3, 1, 0));
    tbl.push_back(mk(OR, 20'h0,     20'h00201, 2, 1, 0));
    tbl.push_back(mk(OR, 20'h0,     20'h00101, 1, 1, 0));
    tbl.push_back(mk(OR, 20'h0,     20'h00012, 0, 1, 0));
    tbl.push_back(mk(OR, 20'h0,     20'h00012, 0, 1, 1));
    tbl.push_back(mk(OX, 20'h0,     20'h00012, 0, 0, 0));
    tbl.push_back(mk(OC, 20'h00050, 20'h00050, 1, 0, 0));
    tbl.push_back(mk(OR|OC|OI, 20'h00777, 20'h00013, 0, 0, 0));
    tbl.push_back(mk(OX|OR, 20'h0,  20'h00013, 0, 0, 1));
    tbl.push_back(mk(OW|OB|OI, 20'h00F00, 20'h00F00, 0, 0, 1));
    tbl.push_back(mk(OB|OI, 20'h00005, 20'h00F05, 0, 0, 1));
    tbl.push_back(mk(OI, 20'h0,     20'h00F06, 0, 0, 1));
    tbl.push_back(mk(OX, 20'h0,     20'h00F06, 0, 0, 0));
    tbl.push_back(mk(0,  20'h0,     20'h00F06, 0, 0, 0));

    foreach (tbl[k]) begin
      ret       = (tbl[k].ops & OR) != 0;
      call      = (tbl[k].ops & OC) != 0;
      write_en  = (tbl[k].ops & OW) != 0;
      branch_en = (tbl[k].ops & OB) != 0;
      inc       = (tbl[k].ops & OI) != 0;
      clr_err   = (tbl[k].ops & OX) != 0;
      write_data = tbl[k].d;
      branch_off = tbl[k].d;
      @(posedge clk);
      #1 check_all($sformatf("vec%0d", k), tbl[k].e_ctr, tbl[k].e_sp, tbl[k].e_ovf, tbl[k].e_udf);
    end
    idle_inputs();
    async_reset("rst2");

    // Random traffic; call/ret rates high enough to hit both stack limits.
    for (int n = 0; n < 400; n++) begin
      ret        = ($urandom_range(0, 99) < 25);
      call       = ($urandom_range(0, 99) < 30);
      write_en   = ($urandom_range(0, 99) < 15);
      branch_en  = ($urandom_range(0, 99) < 20);
      inc        = ($urandom_range(0, 99) < 50);
      clr_err    = ($urandom_range(0, 99) < 10);
      write_data = W'($urandom);
      branch_off = W'($urandom);
      model_step();
      @(posedge clk);
      #1 check_all($sformatf("rnd%0d", n), m_ctr, m_q.size(), m_ovf, m_udf);
    end
    idle_inputs();

    // Push some state, then reset mid-cycle again.
    for (int n = 0; n < 3; n++) begin
      call = 1; write_data = W'(n * 16 + 5);
      model_step();
      @(posedge clk);
      #1 check_all($sformatf("pre%0d", n), m_ctr, m_q.size(), m_ovf, m_udf);
    end
    idle_inputs();
    async_reset("rst3");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
